pcm_interp: RTL and testbench

PCM_INTERP -- requirements
Module: pcm_interp

---
 rtl/pcm_interp.sv | 116 +++++++++++
 tb/tb_pcm_interp.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pcm_interp.sv
// pcm_interp: linear-interpolating upsampler. Each accepted low-rate sample
// becomes the target of a ramp of N = 2^RATIO_LOG2 output cycles. The ramp
// start value is implicit: acc is reloaded with C*N at every wrap, so the
// previous target is always the exact starting point and no error builds up.
module pcm_interp #(
  parameter int WIDTH      = 16,
  parameter int RATIO_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_pcm,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] pcm,
  output logic             underrun
);

  localparam int AW = WIDTH + RATIO_LOG2 + 1;  // accumulator width
  localparam int DW = WIDTH + 1;               // slope width

  localparam logic [RATIO_LOG2-1:0] PH_LAST = '1;
  localparam logic [RATIO_LOG2-1:0] PH_ONE  = 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, state_nx;
  logic                    buf_full;
  logic signed [WIDTH-1:0] buf_q;
  logic signed [WIDTH-1:0] c_q;
  logic signed [DW-1:0]    d_q;
  logic signed [AW-1:0]    acc;
  logic [RATIO_LOG2-1:0]   phase;

  logic                    wrap;
  logic                    accept;
  logic                    consume;
  logic signed [DW-1:0]    d_load;
  logic signed [AW-1:0]    d_ext;
  logic signed [AW-1:0]    c_scaled;

  // Handshake, wrap detection and the arithmetic feeding the datapath.
  always_comb begin
    in_ready = !buf_full && !rst;
    accept   = in_valid && in_ready;
    wrap     = (state == RUN) && (phase == PH_LAST);
    // The buffer drains at start-up and at every wrap; in_ready is low then,
    // so an input on the same edge never races the drain.
    consume  = buf_full && ((state == IDLE) || wrap);
    d_load   = {buf_q[WIDTH-1], buf_q} - {c_q[WIDTH-1], c_q};
    d_ext    = {{(AW-DW){d_q[DW-1]}}, d_q};
    c_scaled = {c_q[WIDTH-1], c_q, {RATIO_LOG2{1'b0}}};
  end

  // Next state: leave IDLE once the first sample is buffered; only reset returns.
  always_comb begin
    state_nx = state;
    if (state == IDLE && buf_full) state_nx = RUN;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // One-entry input buffer, ramp registers and underrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_q    <= '0;
      c_q      <= '0;
      d_q      <= '0;
      acc      <= '0;
      phase    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (accept)       begin buf_full <= 1'b1; buf_q <= in_pcm; end
      else if (consume) buf_full <= 1'b0;

      case (state)
        IDLE: begin
          acc   <= '0;
          phase <= '0;
          // C is still zero here, so d_load is the first sample itself.
          if (buf_full) begin
            c_q <= buf_q;
            d_q <= d_load;
          end
        end
        RUN: begin
          if (wrap) begin
            acc   <= c_scaled;
            phase <= '0;
            if (buf_full) begin
              c_q <= buf_q;
              d_q <= d_load;
            end else begin
              d_q      <= '0;
              underrun <= 1'b1;
            end
          end else begin
            acc   <= acc + d_ext;
            phase <= phase + PH_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Arithmetic shift floors toward -inf; the result always lies between the
  // ramp endpoints, so truncating to WIDTH is lossless.
  assign pcm = WIDTH'(acc >>> RATIO_LOG2);

endmodule

// File: tb/tb_pcm_interp.sv
// Directed bench for pcm_interp at WIDTH=16, N=4.
module tb_pcm_interp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_pcm;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pcm;
  logic        underrun;

  int passed = 0;
  int total  = 0;
  int acc_cnt;
  logic exp_rdy;

  pcm_interp #(.WIDTH(16), .RATIO_LOG2(2)) dut (
    .clk(clk), .rst(rst), .in_pcm(in_pcm), .in_valid(in_valid),
    .in_ready(in_ready), .pcm(pcm), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_pcm(input string tag, input int exp);
    chk(tag, 32'($signed(pcm)), exp);
  endtask

  // Accept v on the next edge (phase 0, buffer empty), then run to the wrap.
  task automatic feed(input logic [15:0] v);
    in_valid = 1'b1;
    in_pcm   = v;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  // Check a 5-point ramp starting right after a wrap; ends on the next wrap.
  task automatic ramp5(input string tag, input int a, input int b, input int c,
                       input int d, input int e, input logic und_end);
    chk_pcm({tag, "_0"}, a);
    chk({tag, "_und0"}, 32'(underrun), 0);
    tick(); chk_pcm({tag, "_1"}, b);
    tick(); chk_pcm({tag, "_2"}, c);
    tick(); chk_pcm({tag, "_3"}, d);
    tick(); chk_pcm({tag, "_4"}, e);
    chk({tag, "_und4"}, 32'(underrun), 32'(und_end));
  endtask

  // Start from IDLE: 100 and 200 back-to-back.
  task automatic startup(input string tag);
    int exp_a[9];
    exp_a = '{0, 25, 50, 75, 100, 125, 150, 175, 200};
    in_valid = 1'b1;
    in_pcm   = 16'd100;
    tick();
    chk({tag, "_full_rdy"}, 32'(in_ready), 0);
    in_pcm = 16'd200;
    tick();
    chk({tag, "_run_rdy"}, 32'(in_ready), 1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      if (i == 1) in_valid = 1'b0;
      chk_pcm($sformatf("%s_pcm%0d", tag, i), exp_a[i]);
      chk($sformatf("%s_und%0d", tag, i), 32'(underrun), (i == 8) ? 1 : 0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pcm = '0;
    tick(); tick();
    chk_pcm("rst_pcm", 0);
    chk("rst_und", 32'(underrun), 0);
    chk("rst_rdy", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("rel_rdy", 32'(in_ready), 1);

    startup("start");

    // Downward ramp 100 -> -100.
    feed(16'd100);
    feed(-16'sd100);
    ramp5("down", 100, 50, 0, -50, -100, 1'b1);

    // Full-scale swing.
    feed(16'sd32767);
    feed(-16'sd32768);
    ramp5("full", 32767, 16383, -1, -16385, -32768, 1'b1);

    // Underrun hold at 100, then recovery with 300.
    feed(16'd100);
    tick(); tick(); tick(); tick();
    chk_pcm("ur_wrap1", 100);
    chk("ur_und1", 32'(underrun), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pcm($sformatf("ur_hold%0d", i), 100);
      chk($sformatf("ur_undlow%0d", i), 32'(underrun), 0);
    end
    tick();
    chk_pcm("ur_wrap2", 100);
    chk("ur_und2", 32'(underrun), 1);
    feed(16'd300);
    ramp5("rec", 100, 150, 200, 250, 300, 1'b1);

    // Backpressure: in_valid held high, one accept per 4 cycles.
    acc_cnt  = 0;
    in_valid = 1'b1;
    in_pcm   = 16'd1000;
    for (int i = 0; i < 16; i++) begin
      exp_rdy = ((i % 4) == 0);
      chk($sformatf("bp_rdy%0d", i), 32'(in_ready), 32'(exp_rdy));
      if (in_ready) acc_cnt++;
      tick();
      if (exp_rdy) in_pcm = in_pcm + 16'd1000;
      if ((i % 4) == 3) begin
        chk_pcm($sformatf("bp_pcm%0d", i), (i == 3) ? 300 : 1000 * (i / 4));
        chk($sformatf("bp_und%0d", i), 32'(underrun), 0);
      end
    end
    in_valid = 1'b0;
    chk("bp_count", acc_cnt, 4);

    // Mid-ramp reset with a sample sitting in the buffer.
    in_valid = 1'b1;
    in_pcm   = 16'd5000;
    tick();
    in_valid = 1'b0;
    chk_pcm("mr_ph1", 3250);
    tick();
    chk_pcm("mr_ph2", 3500);
    rst = 1'b1;
    #1;
    chk("mr_rdy_comb", 32'(in_ready), 0);
    tick();
    chk_pcm("mr_pcm", 0);
    chk("mr_und", 32'(underrun), 0);
    chk("mr_rdy", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("mr_rel_rdy", 32'(in_ready), 1);
    chk_pcm("mr_rel_pcm", 0);
    startup("restart");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
